// File: rtl/fu_cdb_buffer.sv
// fu_cdb_buffer: per-FU result FIFO between a functional unit and the CDB arbiter.
// Latency: a result pushed at edge N is offered on fu_done/fu_output_data from cycle N+1.
// Backpressure: in_ready drops when DEPTH entries are held (no same-cycle pop bypass).
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   flush           discard every buffered result (branch mispredict)
//   in_valid/in_data/in_ready   FU-side valid-ready push of a completed result
//   fu_done/fu_output_data      oldest buffered result offered to the CDB arbiter
//   ack             arbiter grant; pops the oldest entry when fu_done is high
//   count           current occupancy, for debug and performance counters

package fu_cdb_pkg;

   // One completed result as broadcast on the CDB.
   typedef struct packed {
      logic [5:0]  pd_s;         // destination physical register
      logic [4:0]  rob_num;      // ROB slot of the producing instruction
      logic [31:0] pd_v;         // result value
      logic [63:0] rvfi_data;    // retirement trace payload (rs1/rs2 read data)
      logic        br_en;        // branch condition evaluated true
      logic [31:0] br_target;    // resolved branch target
      logic [31:0] instr_pc;     // PC of the producing instruction
      logic        instr_is_br;  // producing instruction is a branch
      logic        br_taken;     // branch resolved taken
   } fu_cdb_data_t;

endpackage

module fu_cdb_buffer
   import fu_cdb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   input  fu_cdb_data_t               in_data,
   output logic                       in_ready,
   output logic                       fu_done,
   output fu_cdb_data_t               fu_output_data,
   input  logic                       ack,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   // Pointers rely on natural binary wrap, so the depth must be a power of two.
   generate
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("fu_cdb_buffer: DEPTH must be a power of two and at least 2");
      end
   endgenerate

   fu_cdb_data_t  r_mem [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;

   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_clear;

   // Status is derived from the occupancy register only, so neither in_ready
   // nor fu_done has any combinational dependence on in_valid, in_data or ack.
   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);

   assign w_push  = in_valid & ~w_full;
   assign w_pop   = ack & ~w_empty;
   assign w_clear = rst | flush;

   assign in_ready       = ~w_full;
   assign fu_done        = ~w_empty;
   assign fu_output_data = r_mem[r_head];
   assign count          = r_count;

   // Pointer and occupancy state. Reset and flush both empty the buffer and win
   // over any push or pop presented in the same cycle.
   always_ff @(posedge clk) begin
      if (w_clear) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + PW'(1);
         end
         if (w_pop) begin
            r_head <= r_head + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage carries no reset: a slot is only observable after a push has
   // written it, and a push discarded by flush/reset never lands.
   always_ff @(posedge clk) begin
      if (w_push && !w_clear) begin
         r_mem[r_tail] <= in_data;
      end
   end

endmodule

// File: tb/tb_fu_cdb_buffer.sv
// Bench for fu_cdb_buffer: directed vector table, hand sequences and random traffic,
// all compared against a queue-based model of the buffer.
// Inputs change 1 ns after each rising edge; outputs are sampled at the same point.

module tb_fu_cdb_buffer;
   import fu_cdb_pkg::*;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH+1);

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              in_valid;
   fu_cdb_data_t      in_data;
   logic              in_ready;
   logic              fu_done;
   fu_cdb_data_t      fu_output_data;
   logic              ack;
   logic [CW-1:0]     count;

   always #5 clk = ~clk;

   fu_cdb_buffer #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .in_ready       (in_ready),
      .fu_done        (fu_done),
      .fu_output_data (fu_output_data),
      .ack            (ack),
      .count          (count)
   );

   int vectors     = 0;
   int miscompares = 0;
   int ack_idle    = 0;

   // Reference model: the buffer is simply an ordered list of held results.
   fu_cdb_data_t model_q [$];

   typedef struct {
      logic        r, f, v, a;
      logic [4:0]  rob;
      logic [31:0] pdv;
      logic        done, rdy;
      logic [2:0]  cnt;
      logic [4:0]  orob;
      logic [31:0] opdv;
   } vec_t;

   vec_t tbl [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_data(input string name, input fu_cdb_data_t act, input fu_cdb_data_t exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic fu_cdb_data_t mk(input logic [4:0] rob, input logic [31:0] pdv);
      fu_cdb_data_t d;
      d         = '0;
      d.rob_num = rob;
      d.pd_v    = pdv;
      return d;
   endfunction

   function automatic fu_cdb_data_t rnd_data();
      fu_cdb_data_t d;
      d.pd_s        = 6'($urandom);
      d.rob_num     = 5'($urandom);
      d.pd_v        = $urandom;
      d.rvfi_data   = {$urandom, $urandom};
      d.br_en       = 1'($urandom);
      d.br_target   = $urandom;
      d.instr_pc    = $urandom;
      d.instr_is_br = 1'($urandom);
      d.br_taken    = 1'($urandom);
      return d;
   endfunction

   // Apply one cycle of inputs, advance the model across the edge, and compare.
   task automatic cycle(input logic r, input logic f, input logic v,
                        input fu_cdb_data_t d, input logic a);
      bit do_push, do_pop;
      rst      = r;
      flush    = f;
      in_valid = v;
      in_data  = d;
      ack      = a;
      do_push  = v && (model_q.size() < DEPTH);
      do_pop   = a && (model_q.size() > 0);
      if (a && !r && !f && model_q.size() == 0) begin
         ack_idle++;
         $display("note: ack asserted while fu_done low at %0t (protocol violation)", $time);
      end
      @(posedge clk);
      #1;
      if (r || f) begin
         model_q.delete();
      end else begin
         if (do_pop)  void'(model_q.pop_front());
         if (do_push) model_q.push_back(d);
      end
      chk("model fu_done",  64'(fu_done),  64'(model_q.size() != 0));
      chk("model in_ready", 64'(in_ready), 64'(model_q.size() != DEPTH));
      chk("model count",    64'(count),    64'(model_q.size()));
      if (model_q.size() != 0) begin
         chk_data("model head data", fu_output_data, model_q[0]);
      end
   endtask

   task automatic add(input logic r, input logic f, input logic v, input logic a,
                      input logic [4:0] rob, input logic [31:0] pdv,
                      input logic done, input logic rdy, input logic [2:0] cnt,
                      input logic [4:0] orob, input logic [31:0] opdv);
      vec_t t;
      t.r = r; t.f = f; t.v = v; t.a = a; t.rob = rob; t.pdv = pdv;
      t.done = done; t.rdy = rdy; t.cnt = cnt; t.orob = orob; t.opdv = opdv;
      tbl.push_back(t);
   endtask

   initial begin
      rst      = 1'b1;
      flush    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      ack      = 1'b0;

      //   r  f  v  a  rob pdv            done rdy cnt orob opdv
      // reset, idle, stray ack
      add(1, 0, 0, 0, 0, 0,             0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++)
         add(0, 0, 0, 0, 0, 0,          0, 1, 0, 0, 0);
      add(0, 0, 0, 1, 0, 0,             0, 1, 0, 0, 0);
      // single push, held, then acked
      add(0, 0, 1, 0, 3, 32'hDEADBEEF,  1, 1, 1, 3, 32'hDEADBEEF);
      add(0, 0, 0, 0, 0, 0,             1, 1, 1, 3, 32'hDEADBEEF);
      add(0, 0, 0, 0, 0, 0,             1, 1, 1, 3, 32'hDEADBEEF);
      add(0, 0, 0, 1, 0, 0,             0, 1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0,             0, 1, 0, 0, 0);
      // fill to full, refused push with ack, retry, drain
      add(0, 0, 1, 0, 1, 32'h101,       1, 1, 1, 1, 32'h101);
      add(0, 0, 1, 0, 2, 32'h102,       1, 1, 2, 1, 32'h101);
      add(0, 0, 1, 0, 3, 32'h103,       1, 1, 3, 1, 32'h101);
      add(0, 0, 1, 0, 4, 32'h104,       1, 0, 4, 1, 32'h101);
      add(0, 0, 1, 1, 5, 32'h105,       1, 1, 3, 2, 32'h102);
      add(0, 0, 1, 0, 5, 32'h105,       1, 0, 4, 2, 32'h102);
      add(0, 0, 0, 1, 0, 0,             1, 1, 3, 3, 32'h103);
      add(0, 0, 0, 1, 0, 0,             1, 1, 2, 4, 32'h104);
      add(0, 0, 0, 1, 0, 0,             1, 1, 1, 5, 32'h105);
      add(0, 0, 0, 1, 0, 0,             0, 1, 0, 0, 0);
      // flush beats a same-cycle push and ack
      add(0, 0, 1, 0, 1, 32'h201,       1, 1, 1, 1, 32'h201);
      add(0, 0, 1, 0, 2, 32'h202,       1, 1, 2, 1, 32'h201);
      add(0, 0, 1, 0, 3, 32'h203,       1, 1, 3, 1, 32'h201);
      add(0, 1, 1, 1, 7, 32'h207,       0, 1, 0, 0, 0);
      add(0, 0, 1, 0, 8, 32'h208,       1, 1, 1, 8, 32'h208);
      add(0, 0, 0, 1, 0, 0,             0, 1, 0, 0, 0);
      // reset while full
      add(0, 0, 1, 0, 1, 32'h301,       1, 1, 1, 1, 32'h301);
      add(0, 0, 1, 0, 2, 32'h302,       1, 1, 2, 1, 32'h301);
      add(0, 0, 1, 0, 3, 32'h303,       1, 1, 3, 1, 32'h301);
      add(0, 0, 1, 0, 4, 32'h304,       1, 0, 4, 1, 32'h301);
      add(1, 0, 0, 0, 0, 0,             0, 1, 0, 0, 0);
      add(0, 0, 1, 0, 3, 32'hDEADBEEF,  1, 1, 1, 3, 32'hDEADBEEF);
      add(0, 0, 0, 1, 0, 0,             0, 1, 0, 0, 0);

      foreach (tbl[i]) begin
         cycle(tbl[i].r, tbl[i].f, tbl[i].v, mk(tbl[i].rob, tbl[i].pdv), tbl[i].a);
         chk("tbl fu_done",  64'(fu_done),  64'(tbl[i].done));
         chk("tbl in_ready", 64'(in_ready), 64'(tbl[i].rdy));
         chk("tbl count",    64'(count),    64'(tbl[i].cnt));
         if (tbl[i].done) begin
            chk("tbl rob_num", 64'(fu_output_data.rob_num), 64'(tbl[i].orob));
            chk("tbl pd_v",    64'(fu_output_data.pd_v),    64'(tbl[i].opdv));
         end
      end

      // Steady state at two entries: push and pop every cycle across several wraps.
      cycle(0, 0, 1, mk(8, 32'h408), 0);
      cycle(0, 0, 1, mk(9, 32'h409), 0);
      for (int k = 0; k < 10; k++) begin
         cycle(0, 0, 1, mk(5'(10 + k), 32'h410 + k), 1);
         chk("steady count",   64'(count),                  64'd2);
         chk("steady rob_num", 64'(fu_output_data.rob_num), 64'(9 + k));
      end
      cycle(0, 0, 0, '0, 1);
      chk("steady drain rob_num", 64'(fu_output_data.rob_num), 64'd19);
      cycle(0, 0, 0, '0, 1);
      chk("steady drained", 64'(fu_done), 64'd0);

      // Random traffic with phases biased toward filling and toward draining.
      for (int i = 0; i < 3000; i++) begin
         logic v, a, f, r;
         if (((i / 250) % 2) == 0) begin
            v = ($urandom_range(3) != 0);
            a = ($urandom_range(3) == 0);
         end else begin
            v = ($urandom_range(3) == 0);
            a = ($urandom_range(3) != 0);
         end
         f = ($urandom_range(63) == 0);
         r = ($urandom_range(255) == 0);
         cycle(r, f, v, rnd_data(), a);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
